// File: rtl/frame_writer_if.sv
// Pixel stream sink and framebuffer write port bundle for frame_writer.
// master drives pixels and accepts writes; slave is the writer itself.
interface frame_writer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [23:0]       pixel_axis_tdata;
  logic              pixel_axis_tvalid;
  logic              pixel_axis_tready;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output pixel_axis_tdata,
    output pixel_axis_tvalid,
    input  pixel_axis_tready,
    output hcount_in,
    output vcount_in,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );

  modport slave (
    input  pixel_axis_tdata,
    input  pixel_axis_tvalid,
    output pixel_axis_tready,
    input  hcount_in,
    input  vcount_in,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );
endinterface

// File: rtl/frame_writer.sv
// Captures one tagged pixel frame per start into a framebuffer write port.
// FRAME_WRITER_OOR_CNT_EN adds a saturating out-of-range beat counter.
module frame_writer #(
  parameter int unsigned H_RES  = 320,
  parameter int unsigned V_RES  = 180,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  frame_writer_if.slave     bus,
  output logic              busy,
  output logic              frame_done,
`ifdef FRAME_WRITER_OOR_CNT_EN
  output logic [15:0]       oor_count,
`endif
  output logic [ADDR_W-1:0] pixel_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPT,
    S_DONE
  } state_t;

  localparam logic [10:0] LAST_H = 11'(H_RES - 1);
  localparam logic [9:0]  LAST_V = 10'(V_RES - 1);

  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [23:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_last;
  logic [ADDR_W-1:0] r_count;

  logic        w_tready;
  logic        w_accept;
  logic        w_wr_done;
  logic        w_in_range;
  logic        w_is_last;
  logic [31:0] w_addr_full;

  assign w_wr_done = r_we & bus.mem_ready;

  // Single-entry output register: refill as it drains, hold off after last
  assign w_tready =
    (r_state == S_IDLE) |
    ((r_state == S_CAPT) & ~r_last & (~r_we | bus.mem_ready));

  assign w_accept = bus.pixel_axis_tvalid & w_tready;

  assign w_in_range =
    ({21'd0, bus.hcount_in} < 32'(H_RES)) &
    ({22'd0, bus.vcount_in} < 32'(V_RES));

  assign w_is_last =
    (bus.hcount_in == LAST_H) & (bus.vcount_in == LAST_V);

  assign w_addr_full =
    {22'd0, bus.vcount_in} * 32'(H_RES) + {21'd0, bus.hcount_in};

`ifdef FRAME_WRITER_OOR_CNT_EN
  logic [15:0] r_oor;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_oor <= '0;
    end else if ((r_state == S_IDLE) & start) begin
      r_oor <= '0;
    end else if ((r_state == S_CAPT) & w_accept & ~w_in_range
                 & (r_oor != 16'hFFFF)) begin
      r_oor <= r_oor + 16'd1;
    end
  end

  assign oor_count = r_oor;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CAPT;
            r_busy  <= 1'b1;
            r_last  <= 1'b0;
            r_count <= '0;
          end
        end
        S_CAPT: begin
          if (w_wr_done) begin
            r_we    <= 1'b0;
            r_count <= r_count + 1'b1;
          end
          if (w_accept & w_in_range) begin
            r_we    <= 1'b1;
            r_addr  <= w_addr_full[ADDR_W-1:0];
            r_wdata <= bus.pixel_axis_tdata;
          end
          if (w_accept & w_is_last) begin
            r_last <= 1'b1;
          end
          if (r_last & w_wr_done) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pixel_axis_tready = ~areset & w_tready;
  assign bus.mem_we            = r_we;
  assign bus.mem_addr          = r_addr;
  assign bus.mem_wdata         = r_wdata;
  assign busy                  = r_busy;
  assign frame_done            = r_done;
  assign pixel_count           = r_count;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer on a 4x2 frame.
// Inputs change just after the rising edge; outputs sampled 1 ns later.
module tb_frame_writer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [15:0] pixel_count;
`ifdef FRAME_WRITER_OOR_CNT_EN
  logic [15:0] oor_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  frame_writer_if #(.ADDR_W(16)) bus ();

  frame_writer #(
    .H_RES (4),
    .V_RES (2),
    .ADDR_W(16)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef FRAME_WRITER_OOR_CNT_EN
    .oor_count  (oor_count),
`endif
    .pixel_count(pixel_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic v, input int h, input int vc,
                      input int d);
    bus.pixel_axis_tvalid = v;
    bus.hcount_in         = 11'(h);
    bus.vcount_in         = 10'(vc);
    bus.pixel_axis_tdata  = 24'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    areset        = 1'b1;
    start         = 1'b0;
    bus.mem_ready = 1'b1;
    beat(1'b0, 0, 0, 0);
    #1;
    chk("rst_tready", 32'(bus.pixel_axis_tready), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_cnt", 32'(pixel_count), 0);
    tick();
    tick();
    areset = 1'b0;
    #1;

    // Idle beats are drained and dropped
    for (int i = 0; i < 10; i++) begin
      beat(1'b1, i % 4, i / 4, 100 + i);
      #1;
      chk("idle_tready", 32'(bus.pixel_axis_tready), 1);
      tick();
      chk("idle_we", 32'(bus.mem_we), 0);
    end
    beat(1'b0, 0, 0, 0);
    chk("idle_cnt", 32'(pixel_count), 0);
    chk("idle_busy", 32'(busy), 0);

    // Full frame, raster order, memory always ready
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f1_busy", 32'(busy), 1);
    chk("f1_cnt0", 32'(pixel_count), 0);
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, i % 4, i / 4, i);
      #1;
      chk("f1_tready", 32'(bus.pixel_axis_tready), 1);
      tick();
      chk("f1_we", 32'(bus.mem_we), 1);
      chk("f1_addr", 32'(bus.mem_addr), 32'(i));
      chk("f1_data", 32'(bus.mem_wdata), 32'(i));
      chk("f1_cnt", 32'(pixel_count), 32'(i));
      chk("f1_done_lo", 32'(frame_done), 0);
    end
    beat(1'b0, 0, 0, 0);
    bus.pixel_axis_tvalid = 1'b1;
    #1;
    chk("f1_last_hold", 32'(bus.pixel_axis_tready), 0);
    bus.pixel_axis_tvalid = 1'b0;
    tick();
    chk("f1_done", 32'(frame_done), 1);
    chk("f1_done_busy", 32'(busy), 0);
    chk("f1_done_we", 32'(bus.mem_we), 0);
    chk("f1_done_tready", 32'(bus.pixel_axis_tready), 0);
    chk("f1_cnt8", 32'(pixel_count), 8);
    tick();
    chk("f1_idle_done", 32'(frame_done), 0);
    chk("f1_idle_tready", 32'(bus.pixel_axis_tready), 1);
    chk("f1_idle_cnt", 32'(pixel_count), 8);

    // Frame with start in CAPTURE, out-of-range beat and a stall
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f2_cnt_clr", 32'(pixel_count), 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        beat(1'b1, 5, 0, 24'hFFFFFF);
        #1;
        chk("oor_tready", 32'(bus.pixel_axis_tready), 1);
        tick();
        chk("oor_we", 32'(bus.mem_we), 0);
        chk("oor_cnt", 32'(pixel_count), 4);
      end
      beat(1'b1, i % 4, i / 4, 32'h10 + i);
      start = (i == 2);
      tick();
      start = 1'b0;
      chk("f2_addr", 32'(bus.mem_addr), 32'(i));
      chk("f2_data", 32'(bus.mem_wdata), 32'h10 + i);
      chk("f2_cnt", 32'(pixel_count), 32'(i));
    end
`ifdef FRAME_WRITER_OOR_CNT_EN
    chk("oor_count", 32'(oor_count), 1);
`endif
    bus.mem_ready = 1'b0;
    beat(1'b1, 3, 1, 32'h17);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_tready", 32'(bus.pixel_axis_tready), 0);
      tick();
      chk("stall_we", 32'(bus.mem_we), 1);
      chk("stall_addr", 32'(bus.mem_addr), 6);
      chk("stall_data", 32'(bus.mem_wdata), 32'h16);
      chk("stall_cnt", 32'(pixel_count), 6);
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("unstall_tready", 32'(bus.pixel_axis_tready), 1);
    tick();
    chk("f2_addr7", 32'(bus.mem_addr), 7);
    chk("f2_data7", 32'(bus.mem_wdata), 32'h17);
    chk("f2_cnt7", 32'(pixel_count), 7);
    beat(1'b0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f2_done", 32'(frame_done), 1);
    chk("f2_cnt8", 32'(pixel_count), 8);
    tick();
    chk("f2_done_once", 32'(frame_done), 0);
    chk("f2_idle_busy", 32'(busy), 0);
    chk("f2_keep_cnt", 32'(pixel_count), 8);
    tick();
    chk("f2_idle_busy2", 32'(busy), 0);
    chk("f2_idle_tready", 32'(bus.pixel_axis_tready), 1);

    // Abort mid-frame with a write pending
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i % 4, 0, 32'h20 + i);
      tick();
    end
    chk("ab_we_pre", 32'(bus.mem_we), 1);
    chk("ab_cnt_pre", 32'(pixel_count), 3);
    areset = 1'b1;
    #1;
    chk("ab_we", 32'(bus.mem_we), 0);
    chk("ab_tready", 32'(bus.pixel_axis_tready), 0);
    chk("ab_busy", 32'(busy), 0);
    beat(1'b0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("ab_no_done", 32'(frame_done), 0);
    end
    areset = 1'b0;
    tick();
    chk("ab_no_done2", 32'(frame_done), 0);
    chk("ab_idle_tready", 32'(bus.pixel_axis_tready), 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f3_cnt0", 32'(pixel_count), 0);
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, i % 4, i / 4, 32'h30 + i);
      tick();
      chk("f3_addr", 32'(bus.mem_addr), 32'(i));
      chk("f3_data", 32'(bus.mem_wdata), 32'h30 + i);
      chk("f3_cnt", 32'(pixel_count), 32'(i));
    end
    beat(1'b0, 0, 0, 0);
    tick();
    chk("f3_done", 32'(frame_done), 1);
    chk("f3_cnt8", 32'(pixel_count), 8);
    tick();
    chk("f3_idle_done", 32'(frame_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
